multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: USE_MEM_READY, 1, when 0 the MemReady input is ignored and every memory state lasts exactly one cycle.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 Opcode  input  6  instruction bits [31:26], taken from the instruction register.
REQ-005 funct  input  6  instruction bits [5:0], taken from the instruction register.
REQ-006 Zero  input  1  ALU zero flag.
REQ-007 MemReady  input  1  memory completion strobe for the current access.
REQ-008 IorD, MemWrite, IRWrite, RegDst, MtoRFSel, RFWE, ALUSrcA  output  1 each  datapath controls.
REQ-009 ALUSrcB  output  2  00=RegB, 01=const 4, 10=SignImm, 11=SignImm<<2.
REQ-010 PCSrc  output  2  00=ALUResult, 01=ALUOut, 10=jump target.
REQ-011 PCEn  output  1  PC load enable, equal to PCWrite OR (Branch AND Zero).
REQ-012 ALUsel  output  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT.
REQ-013 IllegalOp  output  1  one-cycle pulse on an unsupported opcode or funct.
REQ-014 State  output  4  current state encoding, for debug.

Function
REQ-015 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
REQ-016 FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUsel=ADD, PCSrc=00; IRWrite and PCWrite asserted only in the cycle MemReady=1; FETCH holds while MemReady=0.
REQ-017 DECODE: ALUSrcA=0, ALUSrcB=11, ALUsel=ADD; next state chosen by Opcode: 0 goes to EXECUTE, 35/43 go to MEMADR, 4 goes to BRANCH, 8 goes to ADDIEX, 2 goes to JUMP; any other opcode pulses IllegalOp and returns to FETCH.
REQ-018 MEMADR: ALUSrcA=1, ALUSrcB=10, ADD; next state MEMRD for opcode 35, MEMWR for opcode 43.
REQ-019 MEMRD: IorD=1; holds until MemReady, then goes to MEMWB.
REQ-020 MEMWR: IorD=1, MemWrite=1 for every held cycle; leaves for FETCH on MemReady.
REQ-021 MEMWB: RegDst=0, MtoRFSel=1, RFWE=1, then goes to FETCH.
REQ-022 EXECUTE: ALUSrcA=1, ALUSrcB=00; funct 100000 selects ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT; any other funct pulses IllegalOp, goes to FETCH and never reaches ALUWB.
REQ-023 ALUWB: RegDst=1, MtoRFSel=0, RFWE=1, then goes to FETCH.
REQ-024 BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, Branch=1, PCSrc=01; PCEn=Zero; then goes to FETCH.
REQ-025 ADDIEX: ALUSrcA=1, ALUSrcB=10, ADD, then ADDIWB; ADDIWB: RegDst=0, MtoRFSel=0, RFWE=1, then goes to FETCH.
REQ-026 JUMP: PCSrc=10, PCWrite=1, then goes to FETCH.
REQ-027 Latency with MemReady=1 every cycle: R-type 4 cycles, lw 5, sw 4, beq 3, addi 4, j 3; each wait cycle adds one.
REQ-028 All outputs are Moore, decoded from State (plus the funct decode in EXECUTE); every unlisted control is 0 in each state.
REQ-029 MemReady is ignored in non-memory states; a MemReady already high on entry to a memory state completes it in that cycle.

Reset
REQ-030 rst=1 forces State to FETCH on the next edge regardless of the current state, including mid-wait in MEMRD or MEMWR.
REQ-031 While rst=1, MemWrite, IRWrite, PCEn, RFWE and IllegalOp are forced to 0.
REQ-032 In the first cycle after rst deasserts, the block is in FETCH.

Structure
REQ-033 State encodings, ALUsel codes, opcode values and funct values live in shared package mips_pkg.
REQ-034 The funct-to-ALUsel decode is sub-module alu_dec, reused from the single-cycle control path.

Verification
REQ-035 Opcode=0, funct=100000, MemReady=1: states FETCH, DECODE, EXECUTE, ALUWB; ALUsel=0010 in EXECUTE; RFWE=1 and RegDst=1 in ALUWB only.
REQ-036 Opcode=35 with MemReady low for 2 cycles in MEMRD: MEMRD is held 3 cycles; MtoRFSel=1 and RFWE=1 one cycle later; total 7 cycles.
REQ-037 Opcode=43: MemWrite=1 in every MEMWR cycle; RFWE stays 0 throughout the instruction.
REQ-038 Opcode=4 with Zero=1 gives PCEn=1 in BRANCH; with Zero=0, PCEn=0; both take 3 cycles.
REQ-039 Opcode=63, or Opcode=0 with funct=000111: IllegalOp pulses for exactly one cycle, State returns to FETCH, and no write enable is asserted.
REQ-040 rst asserted while in MEMWR: MemWrite=0 in that cycle, and State=FETCH after the next edge.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS control path.
// Holds the multicycle FSM state encodings, ALU select codes, opcode and
// funct values, datapath mux select codes, and the control-word struct that
// the multicycle controller decodes from its state.
package mips_pkg;

  // FSM state encodings (also driven on the State debug output)
  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECUTE = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;

  // ALU select codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // Opcodes (instruction bits [31:26])
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  // R-type funct values (instruction bits [5:0])
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  // ALU B-operand select
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PC source select
  localparam logic [1:0] PC_ALURES = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // Per-state control word. pcwrite/branch are internal; they combine with
  // Zero into PCEn at the top level.
  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       mtorfsel;
    logic       rfwe;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
    logic [3:0] alusel;
    logic       illegal;
  } ctrl_t;

  // True for opcodes the multicycle controller implements.
  function automatic logic is_known_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/alu_dec.sv
// alu_dec: R-type funct to ALU select decode, shared with the single-cycle
// control path.
// Ports:
//   funct   in  [5:0] instruction bits [5:0]
//   alusel  out [3:0] ALU select code (ALU_AND when funct is unsupported)
//   illegal out       high when funct is not one of ADD/SUB/AND/OR/SLT
module alu_dec
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alusel,
  output logic       illegal
);

  always_comb begin
    alusel  = ALU_AND;
    illegal = 1'b0;
    case (funct)
      F_ADD:   alusel = ALU_ADD;
      F_SUB:   alusel = ALU_SUB;
      F_AND:   alusel = ALU_AND;
      F_OR:    alusel = ALU_OR;
      F_SLT:   alusel = ALU_SLT;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore FSM controller for a multicycle MIPS datapath
// (R-type, lw, sw, beq, addi, j).
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   Opcode, funct         instruction fields from the instruction register
//   Zero                  ALU zero flag (used only in BRANCH)
//   MemReady              memory completion strobe
//   IorD .. ALUSrcA       single-bit datapath controls
//   ALUSrcB, PCSrc        datapath mux selects
//   PCEn                  PC load enable = PCWrite | (Branch & Zero)
//   ALUsel                ALU operation select
//   IllegalOp             one-cycle pulse on unsupported opcode/funct
//   State                 current FSM state, for debug
//
// Memory handshake: a memory state (FETCH, MEMRD, MEMWR) presents its access
// for as many cycles as MemReady is low and completes in the first cycle it
// samples MemReady high, including the cycle of entry. MemReady is ignored in
// every other state. With USE_MEM_READY=0 each memory access completes in
// one cycle.
module multicycle_ctrl
  import mips_pkg::*;
#(
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Opcode,
  input  logic [5:0] funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MtoRFSel,
  output logic       RFWE,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic [3:0] ALUsel,
  output logic       IllegalOp,
  output logic [3:0] State
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  ctrl_t      ctrl;
  logic       mem_rdy;
  logic       op_ok;
  logic [3:0] rtype_alusel;
  logic       funct_bad;

  assign mem_rdy = USE_MEM_READY ? MemReady : 1'b1;
  assign op_ok   = is_known_op(Opcode);

  alu_dec u_alu_dec (
    .funct   (funct),
    .alusel  (rtype_alusel),
    .illegal (funct_bad)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:   state_d = mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Opcode)
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = mem_rdy ? S_MEMWB : S_MEMRD;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   state_d = mem_rdy ? S_FETCH : S_MEMWR;
      // An unsupported funct abandons the instruction before write-back.
      S_EXECUTE: state_d = funct_bad ? S_FETCH : S_ALUWB;
      S_ALUWB:   state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  // Moore output decode; every control not named in a state stays 0.
  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.alusel  = ALU_ADD;
        ctrl.pcsrc   = PC_ALURES;
        // IR and PC load only when the instruction word has arrived.
        ctrl.irwrite = mem_rdy;
        ctrl.pcwrite = mem_rdy;
      end
      S_DECODE: begin
        ctrl.alusrcb = SRCB_IMM_SH;
        ctrl.alusel  = ALU_ADD;
        ctrl.illegal = ~op_ok;
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.alusel  = ALU_ADD;
      end
      S_MEMRD: ctrl.iord = 1'b1;
      S_MEMWB: begin
        ctrl.mtorfsel = 1'b1;
        ctrl.rfwe     = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_REG;
        ctrl.alusel  = rtype_alusel;
        ctrl.illegal = funct_bad;
      end
      S_ALUWB: begin
        ctrl.regdst = 1'b1;
        ctrl.rfwe   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_REG;
        ctrl.alusel  = ALU_SUB;
        ctrl.branch  = 1'b1;
        ctrl.pcsrc   = PC_ALUOUT;
      end
      S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.alusel  = ALU_ADD;
      end
      S_ADDIWB: ctrl.rfwe = 1'b1;
      S_JUMP: begin
        ctrl.pcsrc   = PC_JUMP;
        ctrl.pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign IorD     = ctrl.iord;
  assign RegDst   = ctrl.regdst;
  assign MtoRFSel = ctrl.mtorfsel;
  assign ALUSrcA  = ctrl.alusrca;
  assign ALUSrcB  = ctrl.alusrcb;
  assign PCSrc    = ctrl.pcsrc;
  assign ALUsel   = ctrl.alusel;
  assign State    = state_q;

  // State-changing strobes are suppressed during reset so a reset that lands
  // mid-instruction cannot corrupt memory, registers or the PC.
  assign MemWrite  = ctrl.memwrite & ~rst;
  assign IRWrite   = ctrl.irwrite  & ~rst;
  assign RFWE      = ctrl.rfwe     & ~rst;
  assign IllegalOp = ctrl.illegal  & ~rst;
  assign PCEn      = (ctrl.pcwrite | (ctrl.branch & Zero)) & ~rst;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: self-checking bench for multicycle_ctrl.
// A reference model expands each instruction into its expected per-cycle
// sequence of (MemReady drive, expected output vector); the driver replays it
// and compares every cycle.
module tb_multicycle_ctrl;
  import mips_pkg::*;

  localparam int W = 21;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [5:0] Opcode, funct;
  logic       Zero, MemReady;
  logic       IorD, MemWrite, IRWrite, RegDst, MtoRFSel, RFWE, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic       PCEn, IllegalOp;
  logic [3:0] ALUsel, State;

  multicycle_ctrl #(.USE_MEM_READY(1'b1)) dut (
    .clk(clk), .rst(rst), .Opcode(Opcode), .funct(funct), .Zero(Zero),
    .MemReady(MemReady), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MtoRFSel(MtoRFSel), .RFWE(RFWE), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .PCEn(PCEn), .ALUsel(ALUsel),
    .IllegalOp(IllegalOp), .State(State)
  );

  logic [W-1:0] obs;
  assign obs = {State, IorD, MemWrite, IRWrite, RegDst, MtoRFSel, RFWE,
                ALUSrcA, ALUSrcB, PCSrc, PCEn, ALUsel, IllegalOp};

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic         mr_q[$];
  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [W-1:0] mk(
    input logic [3:0] st, input logic iord, mw, irw, rd, mtr, rfwe, sa,
    input logic [1:0] sb, pcs, input logic pcen, input logic [3:0] alu,
    input logic ill);
    return {st, iord, mw, irw, rd, mtr, rfwe, sa, sb, pcs, pcen, alu, ill};
  endfunction

  function automatic logic rnd_bit();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] ref_alu(input logic [5:0] fn, output logic ok);
    ok = 1'b1;
    case (fn)
      6'b100000: return 4'b0010;
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0111;
      default: begin ok = 1'b0; return 4'b0000; end
    endcase
  endfunction

  task automatic push(input logic mr, input logic [W-1:0] v);
    mr_q.push_back(mr);
    exp_q.push_back(v);
  endtask

  // Reference model: expected cycle sequence for one instruction.
  // wf = fetch wait cycles, wm = data memory wait cycles.
  task automatic gen_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int wf, input int wm);
    logic legal;
    logic fok;
    logic [3:0] alu;
    legal = (op == 6'd0) || (op == 6'd35) || (op == 6'd43) ||
            (op == 6'd4) || (op == 6'd8) || (op == 6'd2);
    for (int i = 0; i < wf; i++)
      push(1'b0, mk(S_FETCH, 0,0,0,0,0,0, 0, 2'b01, 2'b00, 0, 4'b0010, 0));
    push(1'b1, mk(S_FETCH, 0,0,1,0,0,0, 0, 2'b01, 2'b00, 1, 4'b0010, 0));
    push(rnd_bit(), mk(S_DECODE, 0,0,0,0,0,0, 0, 2'b11, 2'b00, 0, 4'b0010, !legal));
    if (legal) begin
      case (op)
        6'd0: begin
          alu = ref_alu(fn, fok);
          push(rnd_bit(), mk(S_EXECUTE, 0,0,0,0,0,0, 1, 2'b00, 2'b00, 0, alu, !fok));
          if (fok)
            push(rnd_bit(), mk(S_ALUWB, 0,0,0,1,0,1, 0, 2'b00, 2'b00, 0, 4'b0000, 0));
        end
        6'd35: begin
          push(rnd_bit(), mk(S_MEMADR, 0,0,0,0,0,0, 1, 2'b10, 2'b00, 0, 4'b0010, 0));
          for (int i = 0; i < wm; i++)
            push(1'b0, mk(S_MEMRD, 1,0,0,0,0,0, 0, 2'b00, 2'b00, 0, 4'b0000, 0));
          push(1'b1, mk(S_MEMRD, 1,0,0,0,0,0, 0, 2'b00, 2'b00, 0, 4'b0000, 0));
          push(rnd_bit(), mk(S_MEMWB, 0,0,0,0,1,1, 0, 2'b00, 2'b00, 0, 4'b0000, 0));
        end
        6'd43: begin
          push(rnd_bit(), mk(S_MEMADR, 0,0,0,0,0,0, 1, 2'b10, 2'b00, 0, 4'b0010, 0));
          for (int i = 0; i < wm; i++)
            push(1'b0, mk(S_MEMWR, 1,1,0,0,0,0, 0, 2'b00, 2'b00, 0, 4'b0000, 0));
          push(1'b1, mk(S_MEMWR, 1,1,0,0,0,0, 0, 2'b00, 2'b00, 0, 4'b0000, 0));
        end
        6'd4:
          push(rnd_bit(), mk(S_BRANCH, 0,0,0,0,0,0, 1, 2'b00, 2'b01, z, 4'b0110, 0));
        6'd8: begin
          push(rnd_bit(), mk(S_ADDIEX, 0,0,0,0,0,0, 1, 2'b10, 2'b00, 0, 4'b0010, 0));
          push(rnd_bit(), mk(S_ADDIWB, 0,0,0,0,0,1, 0, 2'b00, 2'b00, 0, 4'b0000, 0));
        end
        default:
          push(rnd_bit(), mk(S_JUMP, 0,0,0,0,0,0, 0, 2'b00, 2'b10, 1, 4'b0000, 0));
      endcase
    end
  endtask

  // ---------------- driver ----------------
  // Entered just after a falling edge; each step drives MemReady, samples
  // mid-low-phase, then advances to the next falling edge.
  task automatic run_trace(input string name, input int max_steps);
    logic [W-1:0] e;
    int step;
    step = 0;
    while (exp_q.size() > 0 && step < max_steps) begin
      MemReady = mr_q.pop_front();
      e = exp_q.pop_front();
      #1;
      n_checks++;
      if (obs !== e) begin
        n_errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, step, obs, e);
      end
      @(negedge clk);
      step++;
    end
    exp_q.delete();
    mr_q.delete();
  endtask

  task automatic run_instr(input string name, input logic [5:0] op,
                           input logic [5:0] fn, input logic z,
                           input int wf, input int wm);
    Opcode = op; funct = fn; Zero = z;
    gen_instr(op, fn, z, wf, wm);
    run_trace(name, 1000);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; MemReady = 1'b1; Opcode = 6'd0; funct = 6'd0; Zero = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (State !== S_FETCH) begin
      n_errors++;
      $display("FAIL reset_state: got %h expected %h", State, S_FETCH);
    end
    n_checks++;
    if ({MemWrite, IRWrite, PCEn, RFWE, IllegalOp} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_strobes: got %b expected 00000",
               {MemWrite, IRWrite, PCEn, RFWE, IllegalOp});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_rtype();
    logic [5:0] fns[5];
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    run_instr("rtype_add", 6'd0, 6'b100000, 1'b0, 0, 0);
    foreach (fns[i])
      run_instr("rtype_mix", 6'd0, fns[i], rnd_bit(), $urandom_range(0, 2), 0);
  endtask

  task automatic test_lw_wait();
    run_instr("lw_wait2", 6'd35, 6'd0, 1'b0, 0, 2);
    run_instr("lw_nowait", 6'd35, 6'd0, 1'b0, 0, 0);
  endtask

  task automatic test_sw();
    run_instr("sw_wait2", 6'd43, 6'd0, 1'b0, 1, 2);
    run_instr("sw_nowait", 6'd43, 6'd0, 1'b1, 0, 0);
  endtask

  task automatic test_beq();
    run_instr("beq_taken", 6'd4, 6'd0, 1'b1, 0, 0);
    run_instr("beq_not_taken", 6'd4, 6'd0, 1'b0, 0, 0);
  endtask

  task automatic test_addi_j();
    run_instr("addi", 6'd8, 6'd0, 1'b0, 0, 0);
    run_instr("jump", 6'd2, 6'd0, 1'b0, 1, 0);
  endtask

  task automatic test_illegal();
    run_instr("illegal_op63", 6'd63, 6'd0, 1'b0, 0, 0);
    run_instr("illegal_funct7", 6'd0, 6'b000111, 1'b0, 0, 0);
    run_instr("after_illegal", 6'd8, 6'd0, 1'b0, 0, 0);
  endtask

  // Reset in the middle of a memory wait; partial trace then reset.
  task automatic test_reset_mid(input string name, input logic [5:0] op);
    Opcode = op; funct = 6'd0; Zero = 1'b0;
    gen_instr(op, 6'd0, 1'b0, 0, 3);
    run_trace(name, 4);
    rst = 1'b1; MemReady = 1'b0;
    #1;
    n_checks++;
    if ({MemWrite, IRWrite, PCEn, RFWE, IllegalOp} !== 5'b0) begin
      n_errors++;
      $display("FAIL %s_strobes: got %b expected 00000", name,
               {MemWrite, IRWrite, PCEn, RFWE, IllegalOp});
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (State !== S_FETCH) begin
      n_errors++;
      $display("FAIL %s_state: got %h expected %h", name, State, S_FETCH);
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [5:0] ops[6];
    logic [5:0] fns[5];
    logic [5:0] op, fn;
    ops = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd8, 6'd2};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        do op = 6'($urandom_range(0, 63));
        while (op inside {6'd0, 6'd35, 6'd43, 6'd4, 6'd8, 6'd2});
      end else begin
        op = ops[$urandom_range(0, 5)];
      end
      if ($urandom_range(0, 9) == 0) begin
        do fn = 6'($urandom_range(0, 63));
        while (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010});
      end else begin
        fn = fns[$urandom_range(0, 4)];
      end
      run_instr("random", op, fn, rnd_bit(), $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw();
    test_beq();
    test_addi_j();
    test_illegal();
    test_reset_mid("reset_in_memwr", 6'd43);
    test_reset_mid("reset_in_memrd", 6'd35);
    run_instr("post_reset_lw", 6'd35, 6'd0, 1'b0, 0, 1);
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
